mmcm_ps_sequencer: RTL

- Sequences fine phase-shift steps on the ADC-clock MMCM dynamic phase-shift port (psen/psincdec/psdone).
- Host writes a signed step request through one single-cycle command. The block issues one psen pulse per step and waits for psdone before the next pulse.
- Keeps a signed running phase position and reports busy, remaining steps and error status.
- Sits in the lb_clk domain. It replaces direct host drive of the MMCM psen and psincdec pins.

---
 rtl/mmcm_ps_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mmcm_ps_sequencer.sv
// Fine phase-shift sequencer for the ADC-clock MMCM dynamic phase-shift port.
// Optional psdone timeout is built when PS_TIMEOUT_EN is defined.
module mmcm_ps_sequencer #(
    parameter int unsigned CW      = 12,
    parameter int unsigned PW      = 16,
    parameter int unsigned GAP     = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dir,
    input  logic [CW-1:0] nsteps,
    input  logic          abort,
    input  logic          pos_clear,
    input  logic          mmcm_locked,
    input  logic          psdone,
    output logic          psen,
    output logic          psincdec,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] remaining,
    output logic [PW-1:0] position,
    output logic          err_unlock,
    output logic          err_timeout
);

    localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [PW-1:0] POS_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] POS_MIN = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP} state_t;

    state_t        state, state_n;
    logic          psen_n, psincdec_n, busy_n, done_n;
    logic [CW-1:0] remaining_n;
    logic [PW-1:0] position_n;
    logic          err_unlock_n, err_timeout_n;
    logic          abort_pend, abort_pend_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;

`ifdef PS_TIMEOUT_EN
    localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    logic [TW-1:0] wait_cnt, wait_cnt_n;
`endif

    // Next-state and next-value logic; lock loss overrides everything at the end.
    always_comb begin
        state_n       = state;
        psincdec_n    = psincdec;
        done_n        = 1'b0;
        remaining_n   = remaining;
        position_n    = position;
        err_unlock_n  = err_unlock;
        err_timeout_n = err_timeout;
        abort_pend_n  = abort_pend;
        gap_cnt_n     = gap_cnt;
`ifdef PS_TIMEOUT_EN
        wait_cnt_n    = wait_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (pos_clear || !mmcm_locked) position_n = '0;
                if (start) begin
                    err_unlock_n  = 1'b0;
                    err_timeout_n = 1'b0;
                    psincdec_n    = dir;
                    remaining_n   = nsteps;
                    if (!mmcm_locked) begin
                        err_unlock_n = 1'b1;
                        done_n       = 1'b1;
                    end else if (nsteps == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                state_n = S_WAIT;
`ifdef PS_TIMEOUT_EN
                wait_cnt_n = '0;
`endif
                if (abort) abort_pend_n = 1'b1;
            end
            S_WAIT: begin
                if (psdone) begin
                    remaining_n = remaining - CW'(1);
                    if (psincdec) begin
                        if (position != POS_MAX) position_n = position + PW'(1);
                    end else if (position != POS_MIN) begin
                        position_n = position - PW'(1);
                    end
                    if (remaining == CW'(1) || abort_pend || abort) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else if (GAP == 0) begin
                        state_n = S_PULSE;
                    end else begin
                        state_n   = S_GAP;
                        gap_cnt_n = '0;
                    end
                end else begin
`ifdef PS_TIMEOUT_EN
                    wait_cnt_n = wait_cnt + TW'(1);
                    if (wait_cnt == TW'(TO_LAST)) begin
                        state_n       = S_IDLE;
                        done_n        = 1'b1;
                        err_timeout_n = 1'b1;
                    end
`endif
                    if (abort) abort_pend_n = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else if (gap_cnt == GW'(GAP_LAST)) begin
                    state_n = S_PULSE;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // An MMCM relock returns its phase to zero, so the position follows.
        if (state != S_IDLE && !mmcm_locked) begin
            state_n       = S_IDLE;
            done_n        = 1'b1;
            err_unlock_n  = 1'b1;
            err_timeout_n = err_timeout;
            position_n    = '0;
            remaining_n   = remaining;
        end

        if (state_n == S_IDLE) abort_pend_n = 1'b0;
        psen_n = (state_n == S_PULSE);
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psen        <= 1'b0;
            psincdec    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            remaining   <= '0;
            position    <= '0;
            err_unlock  <= 1'b0;
            err_timeout <= 1'b0;
            abort_pend  <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            psen        <= psen_n;
            psincdec    <= psincdec_n;
            busy        <= busy_n;
            done        <= done_n;
            remaining   <= remaining_n;
            position    <= position_n;
            err_unlock  <= err_unlock_n;
            err_timeout <= err_timeout_n;
            abort_pend  <= abort_pend_n;
            gap_cnt     <= gap_cnt_n;
        end
    end

`ifdef PS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) wait_cnt <= '0;
        else     wait_cnt <= wait_cnt_n;
    end
`endif

endmodule
